// File: rtl/lander_pkg.sv
// Shared types and default constants for the lunar lander game engine.
package lander_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLYING  = 2'd1,
        LANDED  = 2'd2,
        CRASHED = 2'd3
    } state_e;

    localparam int DEF_FUEL_INIT = 120;
    localparam int DEF_VEL_INIT  = -50;
    localparam int DEF_ALT_INIT  = 500;
    localparam int DEF_GRAVITY   = 5;
    localparam int DEF_SAFE_VEL  = 10;

    // Clamp a signed value into the range of a w-bit two's complement number.
    function automatic int sat_signed(input int v, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -hi - 1;
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/step_divider.sv
// Divides clk_2 into game-step enables: tick is high on every TICK_DIV-th enabled cycle.
module step_divider #(
    parameter int TICK_DIV = 1
) (
    input  logic clk_2,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n)       cnt <= '0;
        else if (clear)     cnt <= '0;
        else if (enable)    cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/lunar_lander_core.sv
// Lunar landing game engine: fuel/velocity/altitude advanced once per game step,
// with start/restart control and a LANDED/CRASHED verdict at touchdown.
module lunar_lander_core
    import lander_pkg::*;
#(
    parameter int W_FUEL    = 8,
    parameter int W_VEL     = 12,
    parameter int W_ALT     = 12,
    parameter int W_BURN    = 7,
    parameter int W_STEPS   = 8,
    parameter int FUEL_INIT = DEF_FUEL_INIT,
    parameter int VEL_INIT  = DEF_VEL_INIT,
    parameter int ALT_INIT  = DEF_ALT_INIT,
    parameter int GRAVITY   = DEF_GRAVITY,
    parameter int SAFE_VEL  = DEF_SAFE_VEL,
    parameter int TICK_DIV  = 1
) (
    input  logic                    clk_2,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [W_BURN-1:0]       burn,
    output logic [W_FUEL-1:0]       fuel,
    output logic signed [W_VEL-1:0] velocity,
    output logic [W_ALT-1:0]        altitude,
    output logic [1:0]              state,
    output logic                    step,
    output logic [W_STEPS-1:0]      steps
);

    // Internal width covers every operand plus sign and one carry bit.
    localparam int WMAX = (W_VEL > W_ALT) ? ((W_VEL > W_FUEL) ? W_VEL : W_FUEL)
                                          : ((W_ALT > W_FUEL) ? W_ALT : W_FUEL);
    localparam int IW = WMAX + 2;

    state_e st, st_nx;
    logic   tick, restart, touchdown, landed_ok;

    logic [W_FUEL-1:0]       act;
    logic signed [IW-1:0]    vel_x, alt_n;
    logic signed [W_VEL-1:0] vel_sat;
    logic [W_ALT-1:0]        alt_sat;

    assign state   = st;
    assign restart = start && (st == LANDED || st == CRASHED);

    step_divider #(.TICK_DIV(TICK_DIV)) u_div (
        .clk_2  (clk_2),
        .reset_n(reset_n),
        .clear  (st != FLYING),
        .enable (st == FLYING),
        .tick   (tick)
    );

    always_comb begin
        act       = (burn < fuel) ? W_FUEL'(burn) : fuel;
        vel_x     = IW'(velocity) - IW'(GRAVITY) + $signed(IW'(act));
        vel_sat   = W_VEL'(sat_signed(int'(vel_x), W_VEL));
        alt_n     = $signed(IW'(altitude)) + IW'(velocity);
        alt_sat   = (alt_n > IW'((1 << W_ALT) - 1)) ? '1 : alt_n[W_ALT-1:0];
        touchdown = (alt_n <= 0);
        landed_ok = (int'(velocity) >= -SAFE_VEL);
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) st <= IDLE;
        else          st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        case (st)
            IDLE:            if (start) st_nx = FLYING;
            FLYING:          if (tick && touchdown) st_nx = landed_ok ? LANDED : CRASHED;
            LANDED, CRASHED: if (start) st_nx = FLYING;
            default:         st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            fuel     <= W_FUEL'(FUEL_INIT);
            velocity <= W_VEL'(VEL_INIT);
            altitude <= W_ALT'(ALT_INIT);
            steps    <= '0;
            step     <= 1'b0;
        end else begin
            step <= tick;
            if (restart) begin
                fuel     <= W_FUEL'(FUEL_INIT);
                velocity <= W_VEL'(VEL_INIT);
                altitude <= W_ALT'(ALT_INIT);
                steps    <= '0;
            end else if (tick) begin
                steps <= (steps == '1) ? steps : steps + 1'b1;
                // On touchdown fuel and velocity hold so velocity reports impact speed.
                if (touchdown) begin
                    altitude <= '0;
                end else begin
                    fuel     <= fuel - act;
                    velocity <= vel_sat;
                    altitude <= alt_sat;
                end
            end
        end
    end

endmodule

// File: tb/tb_lunar_lander_core.sv
// Bench for lunar_lander_core: three instances (default, short-drop landing, TICK_DIV=4)
// each shadowed by an arithmetic game model and checked every cycle plus directed literals.
module tb_lunar_lander_core;

    logic       clk;
    logic [2:0] rst_n;
    logic [2:0] start;
    logic [6:0] burn [3];

    logic [7:0]        fuel_o  [3];
    logic signed [11:0] vel_o  [3];
    logic [11:0]       alt_o   [3];
    logic [1:0]        state_o [3];
    logic              step_o  [3];
    logic [7:0]        steps_o [3];

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  chk_on  = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    lunar_lander_core u0 (
        .clk_2(clk), .reset_n(rst_n[0]), .start(start[0]), .burn(burn[0]),
        .fuel(fuel_o[0]), .velocity(vel_o[0]), .altitude(alt_o[0]),
        .state(state_o[0]), .step(step_o[0]), .steps(steps_o[0])
    );

    lunar_lander_core #(.ALT_INIT(10), .VEL_INIT(-5)) u1 (
        .clk_2(clk), .reset_n(rst_n[1]), .start(start[1]), .burn(burn[1]),
        .fuel(fuel_o[1]), .velocity(vel_o[1]), .altitude(alt_o[1]),
        .state(state_o[1]), .step(step_o[1]), .steps(steps_o[1])
    );

    lunar_lander_core #(.TICK_DIV(4)) u2 (
        .clk_2(clk), .reset_n(rst_n[2]), .start(start[2]), .burn(burn[2]),
        .fuel(fuel_o[2]), .velocity(vel_o[2]), .altitude(alt_o[2]),
        .state(state_o[2]), .step(step_o[2]), .steps(steps_o[2])
    );

    // Game model: one per instance, plain integer arithmetic on the game rules.
    for (genvar g = 0; g < 3; g++) begin : mdl
        localparam int VI = (g == 1) ? -5 : -50;
        localparam int AI = (g == 1) ? 10 : 500;
        localparam int TD = (g == 2) ? 4 : 1;
        int fuel, vel, alt, st, steps, cnt, pulse, act, an;

        always @(posedge clk or negedge rst_n[g]) begin
            if (!rst_n[g]) begin
                fuel = 120; vel = VI; alt = AI; st = 0; steps = 0; cnt = 0; pulse = 0;
            end else begin
                pulse = 0;
                if (st == 0) begin
                    if (start[g]) begin st = 1; cnt = 0; end
                end else if (st == 1) begin
                    if (cnt == TD - 1) begin
                        cnt   = 0;
                        pulse = 1;
                        steps = (steps < 255) ? steps + 1 : 255;
                        act   = (int'(burn[g]) < fuel) ? int'(burn[g]) : fuel;
                        an    = alt + vel;
                        if (an > 0) begin
                            fuel = fuel - act;
                            vel  = vel - 5 + act;
                            if (vel > 2047)  vel = 2047;
                            if (vel < -2048) vel = -2048;
                            alt  = (an > 4095) ? 4095 : an;
                        end else begin
                            alt = 0;
                            st  = (vel >= -10) ? 2 : 3;
                        end
                    end else begin
                        cnt = cnt + 1;
                    end
                end else if (start[g]) begin
                    fuel = 120; vel = VI; alt = AI; steps = 0; cnt = 0; st = 1;
                end
            end
        end
    end

    task automatic cmp(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmp_inst(input int i, input int st, input int f, input int v, input int a,
                            input int s, input int p, input int mst, input int mf, input int mv,
                            input int ma, input int ms, input int mp);
        cmp($sformatf("u%0d.state", i), st, mst);
        cmp($sformatf("u%0d.fuel", i), f, mf);
        cmp($sformatf("u%0d.velocity", i), v, mv);
        cmp($sformatf("u%0d.altitude", i), a, ma);
        cmp($sformatf("u%0d.steps", i), s, ms);
        cmp($sformatf("u%0d.step", i), p, mp);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp_inst(0, int'(state_o[0]), int'(fuel_o[0]), int'(vel_o[0]), int'(alt_o[0]),
                     int'(steps_o[0]), int'(step_o[0]), mdl[0].st, mdl[0].fuel, mdl[0].vel,
                     mdl[0].alt, mdl[0].steps, mdl[0].pulse);
            cmp_inst(1, int'(state_o[1]), int'(fuel_o[1]), int'(vel_o[1]), int'(alt_o[1]),
                     int'(steps_o[1]), int'(step_o[1]), mdl[1].st, mdl[1].fuel, mdl[1].vel,
                     mdl[1].alt, mdl[1].steps, mdl[1].pulse);
            cmp_inst(2, int'(state_o[2]), int'(fuel_o[2]), int'(vel_o[2]), int'(alt_o[2]),
                     int'(steps_o[2]), int'(step_o[2]), mdl[2].st, mdl[2].fuel, mdl[2].vel,
                     mdl[2].alt, mdl[2].steps, mdl[2].pulse);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 3'b000;
        start = 3'b000;
        for (int i = 0; i < 3; i++) burn[i] = '0;
        cyc(3);
        rst_n  = 3'b111;
        chk_on = 1;

        // Reset values and idle hold
        cmp("rst.state", int'(state_o[0]), 0);
        cmp("rst.fuel", int'(fuel_o[0]), 120);
        cmp("rst.velocity", int'(vel_o[0]), -50);
        cmp("rst.altitude", int'(alt_o[0]), 500);
        cmp("rst.steps", int'(steps_o[0]), 0);
        cyc(10);
        cmp("idle.state", int'(state_o[0]), 0);
        cmp("idle.altitude", int'(alt_o[0]), 500);
        cmp("idle.velocity", int'(vel_o[0]), -50);

        // Free fall with burn=0 until crash
        start[0] = 1;
        cyc(1);
        start[0] = 0;
        cmp("fly.state", int'(state_o[0]), 1);
        cyc(1);
        cmp("s1.fuel", int'(fuel_o[0]), 120);
        cmp("s1.velocity", int'(vel_o[0]), -55);
        cmp("s1.altitude", int'(alt_o[0]), 450);
        cmp("s1.step", int'(step_o[0]), 1);
        cyc(1);
        cmp("s2.velocity", int'(vel_o[0]), -60);
        cmp("s2.altitude", int'(alt_o[0]), 395);
        cmp("s2.step", int'(step_o[0]), 1);
        cyc(6);
        cmp("crash.altitude", int'(alt_o[0]), 0);
        cmp("crash.velocity", int'(vel_o[0]), -85);
        cmp("crash.state", int'(state_o[0]), 3);
        cmp("crash.steps", int'(steps_o[0]), 8);
        cyc(5);
        cmp("frozen.state", int'(state_o[0]), 3);
        cmp("frozen.steps", int'(steps_o[0]), 8);
        cmp("frozen.step", int'(step_o[0]), 0);
        cmp("frozen.velocity", int'(vel_o[0]), -85);

        // Restart with burn larger than fuel
        burn[0]  = 7'd127;
        start[0] = 1;
        cyc(1);
        start[0] = 0;
        cmp("restart.state", int'(state_o[0]), 1);
        cmp("restart.fuel", int'(fuel_o[0]), 120);
        cmp("restart.altitude", int'(alt_o[0]), 500);
        cmp("restart.steps", int'(steps_o[0]), 0);
        cyc(1);
        cmp("clamp1.fuel", int'(fuel_o[0]), 0);
        cmp("clamp1.velocity", int'(vel_o[0]), 65);
        cmp("clamp1.altitude", int'(alt_o[0]), 450);
        cyc(1);
        cmp("clamp2.fuel", int'(fuel_o[0]), 0);
        cmp("clamp2.velocity", int'(vel_o[0]), 60);
        cmp("clamp2.altitude", int'(alt_o[0]), 515);
        cmp("clamp2.steps", int'(steps_o[0]), 2);

        // Safe landing on the short-drop instance, then restart
        burn[1]  = 7'd5;
        start[1] = 1;
        cyc(1);
        start[1] = 0;
        cyc(1);
        cmp("land1.velocity", int'(vel_o[1]), -5);
        cmp("land1.altitude", int'(alt_o[1]), 5);
        cmp("land1.fuel", int'(fuel_o[1]), 115);
        cyc(1);
        cmp("land2.altitude", int'(alt_o[1]), 0);
        cmp("land2.state", int'(state_o[1]), 2);
        cmp("land2.velocity", int'(vel_o[1]), -5);
        cyc(3);
        cmp("landed.state", int'(state_o[1]), 2);
        start[1] = 1;
        cyc(1);
        start[1] = 0;
        cmp("reland.state", int'(state_o[1]), 1);
        cmp("reland.fuel", int'(fuel_o[1]), 120);
        cmp("reland.altitude", int'(alt_o[1]), 10);
        cmp("reland.steps", int'(steps_o[1]), 0);

        // Divided step rate; burn wiggles between steps must not matter
        start[2] = 1;
        cyc(1);
        start[2] = 0;
        burn[2]  = 7'd9;
        cyc(2);
        burn[2]  = 7'd0;
        cyc(1);
        cmp("div.steps_before", int'(steps_o[2]), 0);
        cmp("div.alt_before", int'(alt_o[2]), 500);
        cyc(1);
        cmp("div.steps", int'(steps_o[2]), 1);
        cmp("div.altitude", int'(alt_o[2]), 450);
        cmp("div.fuel", int'(fuel_o[2]), 120);
        cmp("div.step", int'(step_o[2]), 1);
        cyc(1);
        cmp("div.step_low", int'(step_o[2]), 0);
        cyc(5);

        // Asynchronous reset mid-flight, checked before the next rising edge
        #2 rst_n[2] = 0;
        #1;
        cmp("areset.state", int'(state_o[2]), 0);
        cmp("areset.altitude", int'(alt_o[2]), 500);
        cmp("areset.velocity", int'(vel_o[2]), -50);
        cmp("areset.steps", int'(steps_o[2]), 0);
        cmp("areset.step", int'(step_o[2]), 0);
        cyc(1);
        rst_n[2] = 1;
        cyc(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
